stopwatch_bcd: RTL and testbench

- Count-up stopwatch: the opposite direction of the team's count-down timer.
- Accumulates elapsed time as packed BCD HH:MM:SS on a 1 Hz tick enable.
- Supports start/stop, clear, and lap (split) freeze of the display.
- Sits beside the count-down timer in the clock top level. Its BCD outputs feed the same display mux directly, so no bin2bcd conversion is needed.

---
 rtl/stopwatch_bcd.sv | 149 ++++++++++++++
 tb/tb_stopwatch_bcd.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// Count-up BCD stopwatch (HH:MM:SS) with start/stop, clear and lap freeze.
// Optional target alarm enabled with `define STOPWATCH_TARGET_EN.
module stopwatch_bcd #(
  parameter int unsigned MAX_HOUR = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
`ifdef STOPWATCH_TARGET_EN
  input  logic [7:0] target_hour_bcd,
  input  logic [7:0] target_minute_bcd,
  input  logic [7:0] target_second_bcd,
  output logic       ring,
`endif
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int unsigned HourLast = MAX_HOUR - 1;
  localparam logic [7:0]  HourLastBcd = {4'(HourLast / 10), 4'(HourLast % 10)};
  localparam logic [7:0]  SixtyLast = 8'h59;

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  state_e      state_q, state_d;
  logic [23:0] live_q, live_d;   // {hour, minute, second} packed BCD
  logic [23:0] lap_q, lap_d;
  logic        overflow_q, overflow_d;
  logic        count_en;
  logic [8:0]  sec_inc, min_inc, hour_inc;

  // Two-digit BCD increment; bit 8 flags a wrap from last back to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [8:0] r;
    if (v == last) begin
      r = 9'h100;
    end else if (v[3:0] == 4'd9) begin
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign count_en = tick_1hz && ((state_q == StRun) || (state_q == StLap));
  assign sec_inc  = bcd_inc(live_q[7:0], SixtyLast);
  assign min_inc  = bcd_inc(live_q[15:8], SixtyLast);
  assign hour_inc = bcd_inc(live_q[23:16], HourLastBcd);

`ifdef STOPWATCH_TARGET_EN
  logic        ring_q, ring_d;
  logic [23:0] target;
  assign target = {target_hour_bcd, target_minute_bcd, target_second_bcd};
`endif

  always_comb begin
    state_d    = state_q;
    live_d     = live_q;
    lap_d      = lap_q;
    overflow_d = 1'b0;
`ifdef STOPWATCH_TARGET_EN
    ring_d     = ring_q;
`endif
    if (clear) begin
      state_d = StIdle;
      live_d  = '0;
      lap_d   = '0;
`ifdef STOPWATCH_TARGET_EN
      ring_d  = 1'b0;
`endif
    end else begin
      if (count_en) begin
        live_d[7:0] = sec_inc[7:0];
        if (sec_inc[8]) begin
          live_d[15:8] = min_inc[7:0];
          if (min_inc[8]) begin
            live_d[23:16] = hour_inc[7:0];
            overflow_d    = hour_inc[8];
          end
        end
      end
      if (start_stop) begin
        unique case (state_q)
          StIdle:  state_d = StRun;
          StRun:   state_d = StPause;
          StLap:   state_d = StPause;
          StPause: state_d = StRun;
          default: state_d = StIdle;
        endcase
      end else if (lap && ((state_q == StRun) || (state_q == StLap))) begin
        // Split captures the value before this cycle's increment.
        lap_d   = live_q;
        state_d = StLap;
      end
`ifdef STOPWATCH_TARGET_EN
      if (start_stop) begin
        ring_d = 1'b0;
      end else if (count_en && (live_d == target) && (target != '0)) begin
        ring_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      live_q     <= '0;
      lap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef STOPWATCH_TARGET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
    end
  end
  assign ring = ring_q;
`endif

  always_comb begin
    if (state_q == StLap) begin
      {hour_bcd, minute_bcd, second_bcd} = lap_q;
    end else begin
      {hour_bcd, minute_bcd, second_bcd} = live_q;
    end
  end

  assign running    = (state_q == StRun) || (state_q == StLap);
  assign lap_active = (state_q == StLap);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a seconds-based reference model feeds expected
// display/flag values into a queue that is drained after each clock edge.
module tb_stopwatch_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [7:0] hour_bcd, minute_bcd, second_bcd;
  logic       running, lap_active, overflow;
  logic [7:0] w_hour_bcd, w_minute_bcd, w_second_bcd;
  logic       w_running, w_lap_active, w_overflow;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  stopwatch_bcd #(.MAX_HOUR(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .hour_bcd  (hour_bcd),
    .minute_bcd(minute_bcd),
    .second_bcd(second_bcd),
    .running   (running),
    .lap_active(lap_active),
    .overflow  (overflow)
  );

  // Shorter hour modulus so a full wrap fits in a modest run.
  stopwatch_bcd #(.MAX_HOUR(12)) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .hour_bcd  (w_hour_bcd),
    .minute_bcd(w_minute_bcd),
    .second_bcd(w_second_bcd),
    .running   (w_running),
    .lap_active(w_lap_active),
    .overflow  (w_overflow)
  );

  always #5 clk = ~clk;

  typedef enum int {MIdle, MRun, MLap, MPause} mstate_e;
  typedef struct {
    string       tag;
    logic [23:0] disp;
    logic [2:0]  flags;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  mstate_e     m_st = MIdle;
  int unsigned m_live = 0;
  int unsigned m_lap = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int unsigned s);
    int unsigned h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // One clock of stimulus; model updated at drive time, compared after the edge.
  task automatic step(input string tag, input logic t, input logic ss, input logic cl,
                      input logic lp, input bit chk);
    sb_entry_t   e;
    int unsigned nl;
    bit          ov;
    @(negedge clk);
    tick_1hz = t; start_stop = ss; clear = cl; lap = lp;
    ov = 1'b0;
    if (cl) begin
      m_st = MIdle; m_live = 0; m_lap = 0;
    end else begin
      nl = m_live;
      if (t && (m_st == MRun || m_st == MLap)) begin
        nl = m_live + 1;
        if (nl == 86400) begin
          nl = 0;
          ov = 1'b1;
        end
      end
      if (ss) begin
        case (m_st)
          MIdle:   m_st = MRun;
          MRun:    m_st = MPause;
          MLap:    m_st = MPause;
          default: m_st = MRun;
        endcase
      end else if (lp && (m_st == MRun || m_st == MLap)) begin
        m_lap = m_live;
        m_st  = MLap;
      end
      m_live = nl;
    end
    if (chk) begin
      e.tag   = tag;
      e.disp  = to_bcd(m_st == MLap ? m_lap : m_live);
      e.flags = {(m_st == MRun || m_st == MLap), (m_st == MLap), ov};
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    if (chk) begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_disp"}, {8'h0, hour_bcd, minute_bcd, second_bcd}, {8'h0, e.disp});
      check_eq({e.tag, "_flags"}, {29'h0, running, lap_active, overflow}, {29'h0, e.flags});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_disp", {8'h0, hour_bcd, minute_bcd, second_bcd}, 32'h0);
    check_eq("reset_flags", {29'h0, running, lap_active, overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 43201; i++) begin
      step("count", 1'b1, 1'b0, 1'b0, 1'b0,
           (i == 9 || i == 10 || i == 61 || i == 3599 || i == 3600 || i == 43200));
      if (i == 43199) begin
        check_eq("wrap_pre", {8'h0, w_hour_bcd, w_minute_bcd, w_second_bcd}, 32'h115959);
      end
      if (i == 43200) begin
        check_eq("wrap_disp", {8'h0, w_hour_bcd, w_minute_bcd, w_second_bcd}, 32'h0);
        check_eq("wrap_flags", {29'h0, w_running, w_lap_active, w_overflow}, 32'h5);
      end
      if (i == 43201) begin
        check_eq("wrap_post", {w_hour_bcd, w_minute_bcd, w_second_bcd, 7'h0, w_overflow},
                 32'h00000100);
      end
    end

    step("clear_tick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("start2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("to5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("lap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("lap_frozen", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("relap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("lap_stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("pause_lap", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("pause_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("lap_tick", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("lap_in_lap", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("lap_ss", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    step("clear2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("start3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("to3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("stop_tick", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("resume_tick", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("run_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("ss_over_lap", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("clear_over_ss", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    step("start4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 754; i++) step("to1234", 1'b1, 1'b0, 1'b0, 1'b0, (i == 754));
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_disp", {8'h0, hour_bcd, minute_bcd, second_bcd}, 32'h0);
    check_eq("async_flags", {29'h0, running, lap_active, overflow}, 32'h0);
    m_st = MIdle; m_live = 0; m_lap = 0;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("post_rst_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("post_rst_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
